// File: rtl/rng_roll_scheduler.sv
// Roll sequencer: samples the free-running generator at doubling intervals, then freezes and signals done.
// Optional build macro RNG_NO_REPEAT_EN forces every sample to differ from the value currently shown.
module rng_roll_scheduler #(
  parameter int WIDTH       = 4,
  parameter int BASE_CYCLES = 262144,
  parameter int NUM_STEPS   = 9,
  parameter int TIMER_W     = 28
) (
  input  logic                           i_clk,
  input  logic                           i_rst,
  input  logic                           i_start,
  input  logic                           i_stop,
  input  logic [WIDTH-1:0]               i_rnd,
  output logic [WIDTH-1:0]               o_value,
  output logic [WIDTH-1:0]               o_prev,
  output logic                           o_sample,
  output logic                           o_busy,
  output logic                           o_done,
  output logic [$clog2(NUM_STEPS+1)-1:0] o_step
);

  localparam int STEP_W = $clog2(NUM_STEPS + 1);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ROLL   = 2'd1;
  localparam logic [1:0] ST_FINISH = 2'd2;

  localparam logic [TIMER_W-1:0] BASE_INT  = TIMER_W'(BASE_CYCLES);
  localparam logic [STEP_W-1:0]  LAST_STEP = STEP_W'(NUM_STEPS - 1);
  localparam logic [STEP_W-1:0]  MAX_STEP  = STEP_W'(NUM_STEPS);

  logic [1:0]         state;
  logic [TIMER_W-1:0] timer;
  logic [TIMER_W-1:0] interval;
  logic [WIDTH-1:0]   next_value;
  logic               take_sample;
  logic               last_sample;

  // NOTE: every signal driven from always_comb gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    next_value = i_rnd;
`ifdef RNG_NO_REPEAT_EN
    if (i_rnd == o_value) next_value = i_rnd + WIDTH'(1);
`endif
  end

  assign take_sample = i_stop || (timer == interval - TIMER_W'(1));
  assign last_sample = i_stop || (o_step == LAST_STEP);
  assign o_busy      = (state != ST_IDLE);

  // NOTE: state registers use non-blocking assignments so every flop updates from pre-edge values.
  always_ff @(posedge i_clk) begin
    // NOTE: only control and output registers exist here; all of them get a defined reset value.
    if (i_rst) begin
      state    <= ST_IDLE;
      timer    <= '0;
      interval <= BASE_INT;
      o_value  <= '0;
      o_prev   <= '0;
      o_sample <= 1'b0;
      o_done   <= 1'b0;
      o_step   <= '0;
    end else begin
      o_sample <= 1'b0;
      o_done   <= 1'b0;
      if (i_start) begin
        // A new request always wins, aborting any roll in flight without a done pulse.
        state    <= ST_ROLL;
        timer    <= '0;
        interval <= BASE_INT;
        o_step   <= '0;
      end else begin
        case (state)
          ST_ROLL: begin
            if (take_sample) begin
              o_value  <= next_value;
              o_sample <= 1'b1;
              o_step   <= (o_step == MAX_STEP) ? o_step : o_step + STEP_W'(1);
              timer    <= '0;
              if (last_sample) begin
                state <= ST_FINISH;
              end else begin
                interval <= interval << 1;
              end
            end else begin
              timer <= timer + TIMER_W'(1);
            end
          end
          ST_FINISH: begin
            o_prev <= o_value;
            o_done <= 1'b1;
            state  <= ST_IDLE;
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_rng_roll_scheduler.sv
// Self-checking bench for rng_roll_scheduler: directed schedule checks plus randomized traffic
// compared each cycle against a schedule-based reference model.
module tb_rng_roll_scheduler;

  localparam int WIDTH  = 4;
  localparam int BASE   = 4;
  localparam int NSTEPS = 3;
  localparam int TW     = 8;
  localparam int SW     = $clog2(NSTEPS + 1);

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic             stop;
  logic [WIDTH-1:0] rnd;
  logic [WIDTH-1:0] value;
  logic [WIDTH-1:0] prev;
  logic             sample;
  logic             busy;
  logic             done;
  logic [SW-1:0]    step;

  int checks = 0;
  int fails  = 0;
  int cyc    = 0;
  bit rnd_count;

  // Reference model: elapsed time since roll start against the closed-form sample schedule.
  bit               m_active;
  bit               m_fin;
  int               m_elapsed;
  int               m_step;
  logic [WIDTH-1:0] m_value;
  logic [WIDTH-1:0] m_prev;
  bit               m_sample;
  bit               m_done;

  always #5 clk = ~clk;

  rng_roll_scheduler #(
    .WIDTH(WIDTH), .BASE_CYCLES(BASE), .NUM_STEPS(NSTEPS), .TIMER_W(TW)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_stop(stop), .i_rnd(rnd),
    .o_value(value), .o_prev(prev), .o_sample(sample), .o_busy(busy),
    .o_done(done), .o_step(step)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [WIDTH-1:0] pick(input logic [WIDTH-1:0] r, input logic [WIDTH-1:0] cur);
`ifdef RNG_NO_REPEAT_EN
    return (r == cur) ? WIDTH'((int'(r) + 1) % (1 << WIDTH)) : r;
`else
    return r;
`endif
  endfunction

  task automatic model_edge();
    m_sample = 1'b0;
    m_done   = 1'b0;
    if (rst) begin
      m_active = 0; m_fin = 0; m_elapsed = 0; m_step = 0; m_value = '0; m_prev = '0;
    end else if (start) begin
      m_active = 1; m_fin = 0; m_elapsed = 0; m_step = 0;
    end else if (m_fin) begin
      m_prev = m_value; m_done = 1'b1; m_fin = 0;
    end else if (m_active) begin
      m_elapsed++;
      if (stop || m_elapsed == BASE * ((1 << (m_step + 1)) - 1)) begin
        m_value  = pick(rnd, m_value);
        m_sample = 1'b1;
        if (m_step < NSTEPS) m_step++;
        if (stop || m_step == NSTEPS) begin
          m_active = 0;
          m_fin    = 1;
        end
      end
    end
  endtask

  // One clock: model follows the edge, outputs compared at the falling edge.
  task automatic cycle();
    @(posedge clk);
    cyc++;
    model_edge();
    @(negedge clk);
    check("value", value, m_value);
    check("prev", prev, m_prev);
    check("sample", sample, m_sample);
    check("done", done, m_done);
    check("busy", busy, m_active || m_fin);
    check("step", step, m_step);
    if (rnd_count) rnd = rnd + 1'b1;
  endtask

  task automatic do_reset();
    rst = 1'b1; start = 1'b0; stop = 1'b0;
    cycle();
    rst = 1'b0;
  endtask

  initial begin
    int offs[$];
    int steps[$];
    logic [WIDTH-1:0] vals[$];
    logic [WIDTH-1:0] last_val;
    logic [WIDTH-1:0] held;
    int done_off;
    int done_cnt;

    rst = 1'b1; start = 1'b1; stop = 1'b1; rnd = '0; rnd_count = 1'b1;
    last_val = '0;

    // 1: reset dominates a held start; idle afterwards.
    repeat (3) cycle();
    check("t1_busy", busy, 0);
    check("t1_value", value, 0);
    check("t1_step", step, 0);
    rst = 1'b0; start = 1'b0; stop = 1'b0;
    repeat (8) cycle();
    check("t1_idle_busy", busy, 0);
    check("t1_idle_sample", sample, 0);

    // 2: full roll schedule.
    start = 1'b1; cycle(); start = 1'b0;
    check("t2_busy_rise", busy, 1);
    done_off = -1;
    for (int k = 1; k <= 30; k++) begin
      cycle();
      if (sample) begin offs.push_back(k); steps.push_back(int'(step)); last_val = value; end
      if (done) begin done_off = k; check("t2_busy_at_done", busy, 0); end
    end
    check("t2_nsamples", offs.size(), 3);
    check("t2_off0", offs.size() > 0 ? offs[0] : -1, 4);
    check("t2_off1", offs.size() > 1 ? offs[1] : -1, 12);
    check("t2_off2", offs.size() > 2 ? offs[2] : -1, 28);
    check("t2_step0", steps.size() > 0 ? steps[0] : -1, 1);
    check("t2_step1", steps.size() > 1 ? steps[1] : -1, 2);
    check("t2_step2", steps.size() > 2 ? steps[2] : -1, 3);
    check("t2_done_off", done_off, 29);
    check("t2_prev", prev, last_val);

    // 3: early stop after the first sample.
    start = 1'b1; cycle(); start = 1'b0;
    repeat (6) cycle();
    stop = 1'b1; cycle(); stop = 1'b0;
    check("t3_stop_sample", sample, 1);
    check("t3_step", step, 2);
    cycle();
    check("t3_done", done, 1);
    check("t3_busy", busy, 0);

    // 4: restart mid-roll; no done for the aborted roll.
    start = 1'b1; cycle(); start = 1'b0;
    done_cnt = 0;
    for (int k = 1; k <= 10; k++) begin
      if (k == 10) start = 1'b1;
      cycle();
      if (done) done_cnt++;
    end
    start = 1'b0;
    offs.delete();
    for (int k = 1; k <= 28; k++) begin
      cycle();
      if (sample) offs.push_back(k);
      if (done) done_cnt++;
    end
    check("t4_no_done", done_cnt, 0);
    check("t4_off0", offs.size() > 0 ? offs[0] : -1, 4);
    check("t4_off1", offs.size() > 1 ? offs[1] : -1, 12);
    check("t4_off2", offs.size() > 2 ? offs[2] : -1, 28);
    repeat (2) cycle();

    // 5: start+stop together restarts; stop in idle is ignored.
    start = 1'b1; cycle(); start = 1'b0;
    repeat (6) cycle();
    start = 1'b1; stop = 1'b1; cycle(); start = 1'b0; stop = 1'b0;
    check("t5_busy", busy, 1);
    check("t5_step", step, 0);
    check("t5_sample", sample, 0);
    repeat (32) cycle();
    held = value;
    stop = 1'b1; cycle(); stop = 1'b0;
    check("t5_idle_sample", sample, 0);
    check("t5_idle_busy", busy, 0);
    check("t5_idle_value", value, held);

    // 6: constant generator output.
    do_reset();
    rnd_count = 1'b0; rnd = 4'h5;
    start = 1'b1; cycle(); start = 1'b0;
    for (int k = 1; k <= 30; k++) begin
      cycle();
      if (sample) vals.push_back(value);
    end
    check("t6_nvals", vals.size(), 3);
    check("t6_v0", vals.size() > 0 ? vals[0] : 'x, 4'h5);
`ifdef RNG_NO_REPEAT_EN
    check("t6_v1", vals.size() > 1 ? vals[1] : 'x, 4'h6);
`else
    check("t6_v1", vals.size() > 1 ? vals[1] : 'x, 4'h5);
`endif
    check("t6_v2", vals.size() > 2 ? vals[2] : 'x, 4'h5);

    // Randomized traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      rnd   = WIDTH'($urandom);
      rst   = ($urandom_range(0, 499) == 0);
      start = ($urandom_range(0, 59) == 0);
      stop  = ($urandom_range(0, 39) == 0);
      cycle();
    end
    rst = 1'b0; start = 1'b0; stop = 1'b0;
    repeat (40) cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/rng_roll_scheduler.md
Name: rng_roll_scheduler

Overview:
Sequencing controller for the free-running 4-bit random generator on the dice/roll display path. On a start pulse it samples the generator at geometrically lengthening intervals, giving a "slowing dice" effect. After a fixed number of samples, or an early stop request, it freezes the value and signals completion. It sits between the debounced key inputs and the display decoder.

Parameters:
WIDTH, 4, bit width of i_rnd, o_value and o_prev
BASE_CYCLES, 262144, first sampling interval in clock cycles; must be ≥1
NUM_STEPS, 9, samples per roll; must be ≥1
TIMER_W, 28, interval/timer register width; BASE_CYCLES << (NUM_STEPS-1) must fit in TIMER_W bits

Ports:
i_clk  in  1  system clock, single clock domain
i_rst  in  1  synchronous reset, active-high
i_start  in  1  roll request, one-cycle pulse from debouncer
i_stop  in  1  early-stop request, one-cycle pulse
i_rnd  in  WIDTH  current generator output, valid every cycle
o_value  out  WIDTH  displayed roll value
o_prev  out  WIDTH  final value of the previous completed roll
o_sample  out  1  one-cycle pulse: o_value updated this cycle
o_busy  out  1  high in ROLL and FINISH
o_done  out  1  one-cycle pulse at roll completion
o_step  out  TIMER_W? no: $clog2(NUM_STEPS+1)  samples taken in current roll

Behaviour:
- Reset, sampled on a rising edge of i_clk with i_rst=1: state IDLE; o_value=0, o_prev=0, o_sample=0, o_busy=0, o_done=0, o_step=0; timer=0, interval=BASE_CYCLES. Reset dominates all other inputs, including mid-roll.
- States: IDLE, ROLL, FINISH.
- IDLE: o_value holds. i_start=1 → ROLL next edge, with timer=0, interval=BASE_CYCLES, o_step=0.
- ROLL: timer increments every cycle.
  - When timer==interval-1: at the next edge, o_value<=i_rnd, o_sample=1 for one cycle, timer<=0, interval<=interval<<1, o_step<=o_step+1.
  - If that sample is number NUM_STEPS, go to FINISH instead of continuing.
- i_stop=1 in ROLL: next edge takes an immediate final sample (o_value<=i_rnd, o_sample=1, o_step+1), then goes to FINISH regardless of the timer.
- i_start=1 in ROLL or FINISH restarts the roll: ROLL, timer=0, interval=BASE_CYCLES, o_step=0. o_value and o_prev are retained. No o_done is emitted for the aborted roll.
- i_start and i_stop high in the same cycle: start wins.
- i_stop in IDLE or FINISH: ignored.
- FINISH: lasts one cycle. Next edge: o_prev<=o_value, o_done=1 for one cycle, state IDLE, o_busy=0.
- Latency: o_busy rises on the edge after i_start. Samples occur at edges E+BASE·(2^k−1) for k=1..NUM_STEPS, where E is the edge at which o_busy rises. o_done follows the last sample by one edge.
- Arithmetic: all counters are unsigned. The interval doubling never overflows under the legal parameter rule. o_step saturates at NUM_STEPS.

Optional Feature:
Macro: RNG_NO_REPEAT_EN
- Defined: at each sample, if i_rnd equals the current o_value, store (i_rnd+1) mod 2^WIDTH instead. Every sample therefore visibly changes the display.
- Undefined: i_rnd is stored unmodified.
- Timing and handshakes are identical in both builds.

Test Plan:
Test parameters unless noted: BASE_CYCLES=4, NUM_STEPS=3, i_rnd driven from a counter.
1. Reset with i_start held high → all outputs 0, state stays IDLE; releasing reset with i_start low → no activity.
2. i_start pulse, o_busy rises at edge E → o_sample at E+4, E+12, E+28; o_step reads 1, 2, 3; o_done at E+29 with o_busy=0; o_prev equals the E+28 sample.
3. i_start, then i_stop at E+6 → single extra sample at E+7, o_done at E+8, o_step=2.
4. Restart via i_start at E+10 → no o_done; new schedule measured from E+11 gives samples at E+15, E+23, E+39.
5. i_start and i_stop together mid-roll → behaves as restart. i_stop in IDLE → no output change.
6. RNG_NO_REPEAT_EN defined, i_rnd held at 4'h5 → o_value sequence 5, 6, 5. Undefined build → 5, 5, 5.
